// File: rtl/univ_reg_nbit.sv
// N-bit universal register: parallel load, shift/rotate both ways, modular inc/dec,
// synchronous set/clear, and a saturating shift counter with a drained flag.
module univ_reg_nbit #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     SET_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0]     RST_VAL = {WIDTH{1'b0}},
  localparam int unsigned         CW      = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             en,
  input  logic             sclr,
  input  logic             sset,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in_r,
  input  logic             ser_in_l,
  output logic [WIDTH-1:0] q,
  output logic             ser_out_l,
  output logic             ser_out_r,
  output logic [CW-1:0]    shift_cnt,
  output logic             drained
);

  typedef enum logic [2:0] {
    ModeHold = 3'b000,
    ModeLoad = 3'b001,
    ModeShl  = 3'b010,
    ModeShr  = 3'b011,
    ModeRol  = 3'b100,
    ModeRor  = 3'b101,
    ModeInc  = 3'b110,
    ModeDec  = 3'b111
  } mode_e;

  localparam logic [CW-1:0] CntMax = CW'(WIDTH);

  logic [WIDTH-1:0] r_q, w_q_d;
  logic [CW-1:0]    r_cnt, w_cnt_d;
  logic             r_drained, w_drained_d;
  logic             w_shift;
  mode_e            w_mode;

  assign w_mode = mode_e'(mode);

  // Shifts are written with << / >> so that WIDTH=1 needs no special-case slicing.
  always_comb begin
    w_q_d   = r_q;
    w_cnt_d = r_cnt;
    w_shift = 1'b0;
    if (sclr) begin
      w_q_d   = RST_VAL;
      w_cnt_d = '0;
    end else if (sset) begin
      w_q_d   = SET_VAL;
      w_cnt_d = '0;
    end else if (en) begin
      unique case (w_mode)
        ModeHold: w_q_d = r_q;
        ModeLoad: begin
          w_q_d   = par_in;
          w_cnt_d = '0;
        end
        ModeShl: begin
          w_q_d   = (r_q << 1) | WIDTH'(ser_in_r);
          w_shift = 1'b1;
        end
        ModeShr: begin
          w_q_d   = (r_q >> 1) | (WIDTH'(ser_in_l) << (WIDTH - 1));
          w_shift = 1'b1;
        end
        ModeRol: begin
          w_q_d   = (r_q << 1) | (r_q >> (WIDTH - 1));
          w_shift = 1'b1;
        end
        ModeRor: begin
          w_q_d   = (r_q >> 1) | (r_q << (WIDTH - 1));
          w_shift = 1'b1;
        end
        ModeInc: w_q_d = r_q + WIDTH'(1);
        ModeDec: w_q_d = r_q - WIDTH'(1);
        default: w_q_d = r_q;
      endcase
    end
    if (w_shift && (r_cnt < CntMax)) begin
      w_cnt_d = r_cnt + CW'(1);
    end
    w_drained_d = (w_cnt_d == CntMax);
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      r_q       <= RST_VAL;
      r_cnt     <= '0;
      r_drained <= 1'b0;
    end else begin
      r_q       <= w_q_d;
      r_cnt     <= w_cnt_d;
      r_drained <= w_drained_d;
    end
  end

  assign q         = r_q;
  assign ser_out_l = r_q[WIDTH-1];
  assign ser_out_r = r_q[0];
  assign shift_cnt = r_cnt;
  assign drained   = r_drained;

endmodule

// File: tb/tb_univ_reg_nbit.sv
// Directed plus randomized bench for univ_reg_nbit (WIDTH=8) against an arithmetic model.
module tb_univ_reg_nbit;

  localparam int W  = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          clr_n = 1'b1;
  logic          en = 1'b0, sclr = 1'b0, sset = 1'b0;
  logic [2:0]    mode = 3'b000;
  logic [W-1:0]  par_in = '0;
  logic          ser_in_r = 1'b0, ser_in_l = 1'b0;
  logic [W-1:0]  q;
  logic          ser_out_l, ser_out_r;
  logic [CW-1:0] shift_cnt;
  logic          drained;

  univ_reg_nbit #(.WIDTH(W)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .en       (en),
    .sclr     (sclr),
    .sset     (sset),
    .mode     (mode),
    .par_in   (par_in),
    .ser_in_r (ser_in_r),
    .ser_in_l (ser_in_l),
    .q        (q),
    .ser_out_l(ser_out_l),
    .ser_out_r(ser_out_r),
    .shift_cnt(shift_cnt),
    .drained  (drained)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int m_q     = 0;  // model value, 0..255
  int m_cnt   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_q"}, 64'(q), 64'(m_q));
    check({tag, "_sol"}, 64'(ser_out_l), 64'(m_q / 128));
    check({tag, "_sor"}, 64'(ser_out_r), 64'(m_q % 2));
    check({tag, "_cnt"}, 64'(shift_cnt), 64'(m_cnt));
    check({tag, "_drn"}, 64'(drained), 64'(m_cnt == W));
  endtask

  // Reference behaviour from the operation rules, using plain integer arithmetic.
  task automatic model_edge();
    bit sh;
    sh = 1'b0;
    if (sclr) begin
      m_q = 0; m_cnt = 0;
    end else if (sset) begin
      m_q = 255; m_cnt = 0;
    end else if (en) begin
      case (int'(mode))
        1: begin m_q = int'(par_in); m_cnt = 0; end
        2: begin m_q = (m_q * 2 + int'(ser_in_r)) % 256; sh = 1'b1; end
        3: begin m_q = m_q / 2 + int'(ser_in_l) * 128; sh = 1'b1; end
        4: begin m_q = (m_q * 2) % 256 + m_q / 128; sh = 1'b1; end
        5: begin m_q = m_q / 2 + (m_q % 2) * 128; sh = 1'b1; end
        6: m_q = (m_q + 1) % 256;
        7: m_q = (m_q + 255) % 256;
        default: ;
      endcase
    end
    if (sh && m_cnt < W) m_cnt++;
  endtask

  task automatic step(input logic e, input logic sc, input logic ss, input logic [2:0] m,
                      input logic [W-1:0] p, input logic sr, input logic sl);
    en = e; sclr = sc; sset = ss; mode = m; par_in = p; ser_in_r = sr; ser_in_l = sl;
    @(posedge clk);
    if (clr_n) model_edge();
    #1;
  endtask

  task automatic async_reset_pulse();
    clr_n = 1'b0;
    m_q = 0; m_cnt = 0;
    #2;
    check_model("rst_pulse");
    clr_n = 1'b1;
  endtask

  initial begin
    logic [7:0] exp_ser;
    // 1: reset while a load is requested
    en = 1'b1; mode = 3'b001; par_in = 8'hA5;
    #2 clr_n = 1'b0;
    #1;
    check("t1_q", 64'(q), 64'h00);
    check("t1_cnt", 64'(shift_cnt), 64'd0);
    check("t1_drn", 64'(drained), 64'd0);
    @(posedge clk); #1;
    check("t1_q_held", 64'(q), 64'h00);
    clr_n = 1'b1;
    step(1, 0, 0, 3'b001, 8'hA5, 0, 0);
    check("t1_load", 64'(q), 64'hA5);
    check_model("t1");

    // 2: drain A5 out LSB-first
    exp_ser = 8'b1010_0101;
    for (int i = 0; i < 8; i++) begin
      check("t2_sor_seq", 64'(ser_out_r), 64'(exp_ser[7-i]));
      step(1, 0, 0, 3'b011, 8'h00, 0, 0);
    end
    check("t2_q", 64'(q), 64'h00);
    check("t2_cnt", 64'(shift_cnt), 64'd8);
    check("t2_drn", 64'(drained), 64'd1);
    step(1, 0, 0, 3'b011, 8'h00, 0, 0);
    check("t2_sat", 64'(shift_cnt), 64'd8);
    check_model("t2");

    // 3: rotates
    step(1, 0, 0, 3'b001, 8'h81, 0, 0);
    step(1, 0, 0, 3'b100, 8'h00, 0, 0);
    check("t3_rol", 64'(q), 64'h03);
    step(1, 0, 0, 3'b101, 8'h00, 0, 0);
    step(1, 0, 0, 3'b101, 8'h00, 0, 0);
    check("t3_ror", 64'(q), 64'hC0);
    check("t3_cnt", 64'(shift_cnt), 64'd3);
    check_model("t3");

    // 4: increment/decrement wrap
    step(1, 0, 0, 3'b001, 8'hFF, 0, 0);
    step(1, 0, 0, 3'b110, 8'h00, 0, 0);
    check("t4_inc", 64'(q), 64'h00);
    check("t4_cnt_a", 64'(shift_cnt), 64'd0);
    step(1, 0, 0, 3'b111, 8'h00, 0, 0);
    check("t4_dec", 64'(q), 64'hFF);
    check("t4_cnt_b", 64'(shift_cnt), 64'd0);

    // 5: priority
    step(1, 1, 1, 3'b001, 8'h5A, 0, 0);
    check("t5_clr", 64'(q), 64'h00);
    step(0, 0, 1, 3'b001, 8'h5A, 0, 0);
    check("t5_set", 64'(q), 64'hFF);
    step(0, 0, 0, 3'b010, 8'h5A, 0, 0);
    check("t5_hold", 64'(q), 64'hFF);
    check_model("t5");

    // 6: reset in the middle of a shift sequence
    step(1, 0, 0, 3'b001, 8'h3C, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 3'b010, 8'h00, 1, 0);
    check("t6_q", 64'(q), 64'hE7);
    check("t6_cnt", 64'(shift_cnt), 64'd3);
    async_reset_pulse();
    check("t6_q_rst", 64'(q), 64'h00);
    step(1, 0, 0, 3'b001, 8'h96, 0, 0);
    check("t6_reload", 64'(q), 64'h96);

    // Random: mostly shifts/rotates so the counter saturates, rare clear/set/reset
    for (int i = 0; i < 400; i++) begin
      logic e, sc, ss;
      logic [2:0] m;
      e  = ($urandom_range(0, 9) != 0);
      sc = ($urandom_range(0, 29) == 0);
      ss = ($urandom_range(0, 29) == 0);
      m  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'($urandom_range(2, 5));
      if ($urandom_range(0, 20) == 0) m = 3'b001;
      step(e, sc, ss, m, 8'($urandom), 1'($urandom), 1'($urandom));
      check_model("rnd");
      if ($urandom_range(0, 59) == 0) async_reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
